// File: rtl/univ_reg_pkg.sv
// univ_reg_pkg: shared constants for the universal register.
//   MODE_W          width of the mode select
//   MODE_HOLD..DEC  mode encodings (fully decoded 3-bit space)
package univ_reg_pkg;

  localparam int unsigned MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_HOLD = 3'd0;
  localparam logic [MODE_W-1:0] MODE_LOAD = 3'd1;
  localparam logic [MODE_W-1:0] MODE_SHL  = 3'd2;
  localparam logic [MODE_W-1:0] MODE_SHR  = 3'd3;
  localparam logic [MODE_W-1:0] MODE_ROTL = 3'd4;
  localparam logic [MODE_W-1:0] MODE_ROTR = 3'd5;
  localparam logic [MODE_W-1:0] MODE_INC  = 3'd6;
  localparam logic [MODE_W-1:0] MODE_DEC  = 3'd7;

endpackage

// File: rtl/univ_reg_dff_en_sync_clear.sv
// dff_en_sync_clear: single-bit flop with synchronous clear and enable.
//   clock  rising-edge clock
//   clear  synchronous active-high clear to RESET_BIT (beats en)
//   en     load enable
//   d      data in
//   q      registered bit
module dff_en_sync_clear #(
  parameter logic RESET_BIT = 1'b0
) (
  input  logic clock,
  input  logic clear,
  input  logic en,
  input  logic d,
  output logic q
);

  always_ff @(posedge clock) begin
    if (clear) begin
      q <= RESET_BIT;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/univ_reg.sv
// univ_reg: WIDTH-bit universal register (hold, load, shift, rotate,
// up/down count) with synchronous clear having priority over mode.
//   clock   rising-edge clock
//   clear   synchronous active-high reset, q <= RESET_VALUE, wrap <= 0
//   mode    operation select (see univ_reg_pkg)
//   d       parallel load data
//   sin_l   serial in, enters bit 0 on SHL
//   sin_r   serial in, enters bit WIDTH-1 on SHR
//   q       register contents
//   sout_l  q[WIDTH-1]
//   sout_r  q[0]
//   wrap    registered, high one cycle after an INC/DEC wrap
//   zero    high when q == 0
// All state lives in dff_en_sync_clear instances; this level is decode only.
module univ_reg
  import univ_reg_pkg::*;
#(
  parameter int unsigned           WIDTH       = 8,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]  d,
  input  logic              sin_l,
  input  logic              sin_r,
  output logic [WIDTH-1:0]  q,
  output logic              sout_l,
  output logic              sout_r,
  output logic              wrap,
  output logic              zero
);

  logic [WIDTH-1:0] q_next;
  logic             q_en;
  logic             wrap_next;

  always_comb begin
    q_next = q;
    case (mode)
      MODE_HOLD: q_next = q;
      MODE_LOAD: q_next = d;
      MODE_SHL:  q_next = {q[WIDTH-2:0], sin_l};
      MODE_SHR:  q_next = {sin_r, q[WIDTH-1:1]};
      MODE_ROTL: q_next = {q[WIDTH-2:0], q[WIDTH-1]};
      MODE_ROTR: q_next = {q[0], q[WIDTH-1:1]};
      MODE_INC:  q_next = q + 1'b1;
      MODE_DEC:  q_next = q - 1'b1;
    endcase
  end

  // Data flops are simply disabled on HOLD; the wrap flop is always
  // enabled so it returns to 0 on every non-wrapping edge.
  assign q_en      = (mode != MODE_HOLD);
  assign wrap_next = ((mode == MODE_INC) && (&q)) ||
                     ((mode == MODE_DEC) && ~(|q));

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    dff_en_sync_clear #(
      .RESET_BIT (RESET_VALUE[i])
    ) u_bit (
      .clock (clock),
      .clear (clear),
      .en    (q_en),
      .d     (q_next[i]),
      .q     (q[i])
    );
  end

  dff_en_sync_clear #(
    .RESET_BIT (1'b0)
  ) u_wrap (
    .clock (clock),
    .clear (clear),
    .en    (1'b1),
    .d     (wrap_next),
    .q     (wrap)
  );

  assign sout_l = q[WIDTH-1];
  assign sout_r = q[0];
  assign zero   = ~(|q);

endmodule

// File: tb/tb_univ_reg.sv
// tb_univ_reg: directed bench for univ_reg at WIDTH=8/RESET_VALUE=A5 and
// WIDTH=2/RESET_VALUE=0, with hand-computed expected values.
module tb_univ_reg;
  import univ_reg_pkg::*;

  logic              clock = 1'b0;
  always #5 clock = ~clock;

  // WIDTH=8 instance
  logic              clear8, sin_l8, sin_r8;
  logic [MODE_W-1:0] mode8;
  logic [7:0]        d8, q8;
  logic              sout_l8, sout_r8, wrap8, zero8;

  // WIDTH=2 instance
  logic              clear2, sin_l2, sin_r2;
  logic [MODE_W-1:0] mode2;
  logic [1:0]        d2, q2;
  logic              sout_l2, sout_r2, wrap2, zero2;

  int unsigned checks = 0;
  int unsigned errors = 0;

  univ_reg #(
    .WIDTH       (8),
    .RESET_VALUE (8'hA5)
  ) u_dut8 (
    .clock  (clock),
    .clear  (clear8),
    .mode   (mode8),
    .d      (d8),
    .sin_l  (sin_l8),
    .sin_r  (sin_r8),
    .q      (q8),
    .sout_l (sout_l8),
    .sout_r (sout_r8),
    .wrap   (wrap8),
    .zero   (zero8)
  );

  univ_reg #(
    .WIDTH       (2),
    .RESET_VALUE (2'b00)
  ) u_dut2 (
    .clock  (clock),
    .clear  (clear2),
    .mode   (mode2),
    .d      (d2),
    .sin_l  (sin_l2),
    .sin_r  (sin_r2),
    .q      (q2),
    .sout_l (sout_l2),
    .sout_r (sout_r2),
    .wrap   (wrap2),
    .zero   (zero2)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] eq, input logic ew, input logic ez);
    chk({tag, ".q"}, q8, eq);
    chk({tag, ".wrap"}, {7'd0, wrap8}, {7'd0, ew});
    chk({tag, ".zero"}, {7'd0, zero8}, {7'd0, ez});
  endtask

  task automatic chk2(input string tag, input logic [1:0] eq, input logic ew);
    chk({tag, ".q"}, {6'd0, q2}, {6'd0, eq});
    chk({tag, ".wrap"}, {7'd0, wrap2}, {7'd0, ew});
  endtask

  initial begin
    clear8 = 1'b1; mode8 = MODE_LOAD; d8 = 8'hFF; sin_l8 = 1'b0; sin_r8 = 1'b0;
    clear2 = 1'b1; mode2 = MODE_INC;  d2 = 2'b11; sin_l2 = 1'b0; sin_r2 = 1'b0;

    // Reset held two edges, LOAD/INC ignored
    tick(); chk8("rst1", 8'hA5, 1'b0, 1'b0); chk2("rst1_w2", 2'd0, 1'b0);
    tick(); chk8("rst2", 8'hA5, 1'b0, 1'b0); chk2("rst2_w2", 2'd0, 1'b0);
    chk("rst.sout_l", {7'd0, sout_l8}, 8'd1);
    chk("rst.sout_r", {7'd0, sout_r8}, 8'd1);
    clear8 = 1'b0;
    mode2  = MODE_HOLD;

    // Load / shift
    mode8 = MODE_LOAD; d8 = 8'b1001_0110;
    tick(); chk8("load96", 8'h96, 1'b0, 1'b0);
    chk("load96.sout_l", {7'd0, sout_l8}, 8'd1);
    chk("load96.sout_r", {7'd0, sout_r8}, 8'd0);
    mode8 = MODE_SHL; sin_l8 = 1'b1;
    tick(); chk8("shl", 8'b0010_1101, 1'b0, 1'b0);
    chk("shl.sout_l", {7'd0, sout_l8}, 8'd0);
    chk("shl.sout_r", {7'd0, sout_r8}, 8'd1);
    mode8 = MODE_SHR; sin_l8 = 1'b0; sin_r8 = 1'b0;
    tick(); chk8("shr", 8'b0001_0110, 1'b0, 1'b0);
    chk("shr.sout_l", {7'd0, sout_l8}, 8'd0);
    chk("shr.sout_r", {7'd0, sout_r8}, 8'd0);
    mode8 = MODE_SHR; sin_r8 = 1'b1;
    tick(); chk8("shr_sin1", 8'b1000_1011, 1'b0, 1'b0);
    mode8 = MODE_HOLD; d8 = 8'h00; sin_r8 = 1'b0;
    tick(); chk8("hold", 8'h8B, 1'b0, 1'b0);

    // Rotate
    mode8 = MODE_LOAD; d8 = 8'h81;
    tick(); chk8("load81", 8'h81, 1'b0, 1'b0);
    mode8 = MODE_ROTL;
    tick(); chk8("rotl", 8'h03, 1'b0, 1'b0);
    mode8 = MODE_ROTR;
    tick(); chk8("rotr1", 8'h81, 1'b0, 1'b0);
    tick(); chk8("rotr2", 8'hC0, 1'b0, 1'b0);

    // Up-count wrap
    mode8 = MODE_LOAD; d8 = 8'hFE;
    tick(); chk8("loadFE", 8'hFE, 1'b0, 1'b0);
    mode8 = MODE_INC;
    tick(); chk8("inc1", 8'hFF, 1'b0, 1'b0);
    tick(); chk8("inc2", 8'h00, 1'b1, 1'b1);
    tick(); chk8("inc3", 8'h01, 1'b0, 1'b0);

    // Down-count wrap
    mode8 = MODE_LOAD; d8 = 8'h01;
    tick(); chk8("load01", 8'h01, 1'b0, 1'b0);
    mode8 = MODE_DEC;
    tick(); chk8("dec1", 8'h00, 1'b0, 1'b1);
    tick(); chk8("dec2", 8'hFF, 1'b1, 1'b0);
    mode8 = MODE_HOLD;
    tick(); chk8("dec_hold", 8'hFF, 1'b0, 1'b0);

    // Clear mid-count, then resume from RESET_VALUE
    mode8 = MODE_LOAD; d8 = 8'h10;
    tick(); chk8("load10", 8'h10, 1'b0, 1'b0);
    mode8 = MODE_INC;
    tick(); chk8("cnt11", 8'h11, 1'b0, 1'b0);
    tick(); chk8("cnt12", 8'h12, 1'b0, 1'b0);
    tick(); chk8("cnt13", 8'h13, 1'b0, 1'b0);
    clear8 = 1'b1;
    tick(); chk8("cnt_clr", 8'hA5, 1'b0, 1'b0);
    clear8 = 1'b0;
    tick(); chk8("cnt_A6", 8'hA6, 1'b0, 1'b0);

    // Clear on the edge after a wrap drops wrap
    mode8 = MODE_LOAD; d8 = 8'hFF;
    tick(); chk8("loadFF", 8'hFF, 1'b0, 1'b0);
    mode8 = MODE_INC;
    tick(); chk8("wrap_pre", 8'h00, 1'b1, 1'b1);
    clear8 = 1'b1;
    tick(); chk8("wrap_clr", 8'hA5, 1'b0, 1'b0);
    clear8 = 1'b0; mode8 = MODE_HOLD;

    // WIDTH=2 wrap sequence 0,1,2,3,0
    clear2 = 1'b0; mode2 = MODE_INC;
    tick(); chk2("w2_1", 2'd1, 1'b0);
    tick(); chk2("w2_2", 2'd2, 1'b0);
    tick(); chk2("w2_3", 2'd3, 1'b0);
    tick(); chk2("w2_0", 2'd0, 1'b1);
    chk("w2.zero", {7'd0, zero2}, 8'd1);
    mode2 = MODE_DEC;
    tick(); chk2("w2_dec", 2'd3, 1'b1);
    mode2 = MODE_SHL; sin_l2 = 1'b0;
    tick(); chk2("w2_shl", 2'd2, 1'b0);
    chk("w2.sout_l", {7'd0, sout_l2}, 8'd1);
    chk("w2.sout_r", {7'd0, sout_r2}, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
